// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Moore). Raises z when the last
// len_r accepted bits equal the loaded pattern; counts matches with saturation.
module seq_detector_param #(
    parameter int unsigned            PAT_W     = 4,
    parameter int unsigned            CNT_W     = 8,
    parameter logic [PAT_W-1:0]       RESET_PAT = PAT_W'(4'b0110),
    parameter logic                   RESET_OVL = 1'b1,
    localparam int unsigned           LW        = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LW-1:0]    pat_len,
    input  logic             overlap,
    input  logic             clear_count,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2,
        HIT     = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_W-1:0]   pat_r, pat_nxt;
    logic [PAT_W-1:0]   hist, hist_nxt;
    logic [PAT_W-1:0]   len_mask;
    logic [LW-1:0]      len_r, len_nxt;
    logic [LW-1:0]      fill, fill_nxt;
    logic [LW-1:0]      base;
    logic [LW-1:0]      len_in;
    logic               ovl_r, ovl_nxt;
    logic               z_nxt;
    logic               accept;
    logic [CNT_W-1:0]   cnt_nxt;

    // Clamp the requested length into 1..PAT_W.
    always_comb begin
        len_in = pat_len;
        if (pat_len == '0) begin
            len_in = LW'(1);
        end else if (pat_len > LW'(PAT_W)) begin
            len_in = LW'(PAT_W);
        end
    end

    // Selects the low len_r bits of history and pattern for comparison.
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < 32'(len_r));
        end
    end

    // Next-state, datapath and counter update.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_r;
        len_nxt   = len_r;
        ovl_nxt   = ovl_r;
        hist_nxt  = hist;
        fill_nxt  = fill;
        base      = fill;
        accept    = 1'b0;
        cnt_nxt   = match_count;
        z_nxt     = 1'b0;

        if (load) begin
            pat_nxt   = pattern;
            len_nxt   = len_in;
            ovl_nxt   = overlap;
            hist_nxt  = '0;
            fill_nxt  = '0;
            state_nxt = EMPTY;
        end else if (valid) begin
            accept   = 1'b1;
            hist_nxt = PAT_W'({hist, x});
            // Non-overlap: a match retires all history bits before the next one.
            base     = (state == HIT && !ovl_r) ? '0 : fill;
            fill_nxt = (base >= len_r) ? len_r : base + LW'(1);
            if (fill_nxt == len_r) begin
                state_nxt = ((hist_nxt & len_mask) == (pat_r & len_mask)) ? HIT : ARMED;
            end else begin
                state_nxt = FILLING;
            end
        end

        if (clear_count) begin
            cnt_nxt = '0;
        end else if (accept && state_nxt == HIT && match_count != '1) begin
            cnt_nxt = match_count + CNT_W'(1);
        end

        z_nxt = (state_nxt == HIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            pat_r       <= RESET_PAT;
            len_r       <= LW'(PAT_W);
            ovl_r       <= RESET_OVL;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_nxt;
            pat_r       <= pat_nxt;
            len_r       <= len_nxt;
            ovl_r       <= ovl_nxt;
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            z           <= z_nxt;
            match_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic, all
// checked against a queue-based model of the accepted bit stream.
module tb_seq_detector_param;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LW    = $clog2(PAT_W + 1);
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             x = 1'b0;
    logic             valid = 1'b0;
    logic             load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [LW-1:0]    pat_len = '0;
    logic             overlap = 1'b0;
    logic             clear_count = 1'b0;
    logic             z;
    logic [CNT_W-1:0] match_count;

    int errors = 0;
    int checks = 0;

    // Model: bits accepted since the last restart, newest at the back.
    bit               m_q[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_z;
    int               m_cnt;

    seq_detector_param #(
        .PAT_W(PAT_W), .CNT_W(CNT_W),
        .RESET_PAT(PAT_W'(4'b0110)), .RESET_OVL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .load(load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .clear_count(clear_count), .z(z), .match_count(match_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge, advance the model at the
    // rising edge, and leave time just after it for sampling.
    task automatic step(input logic v, input logic b, input logic ld,
                        input logic clr, input logic rst);
        bit hit;
        @(negedge clk);
        valid = v; x = b; load = ld; clear_count = clr; reset = rst;
        @(posedge clk);
        if (rst) begin
            m_pat = PAT_W'(4'b0110); m_len = PAT_W; m_ovl = 1'b1;
            m_q.delete(); m_z = 1'b0; m_cnt = 0;
        end else begin
            hit = 1'b0;
            if (ld) begin
                m_pat = pattern;
                m_len = (pat_len == 0) ? 1 : ((int'(pat_len) > PAT_W) ? PAT_W : int'(pat_len));
                m_ovl = overlap;
                m_q.delete();
                m_z = 1'b0;
            end else if (v) begin
                if (m_z && !m_ovl) m_q.delete();
                m_q.push_back(b);
                if (m_q.size() > m_len) void'(m_q.pop_front());
                if (m_q.size() == m_len) begin
                    hit = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
                end
                m_z = hit;
            end
            if (clr) m_cnt = 0;
            else if (hit && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, b[i], 1'b0, 1'b0, 1'b0);
            checks++;
            if (z !== m_z || match_count !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL feed bit%0d: z=%b cnt=%0d, required z=%b cnt=%0d",
                         n - i, z, match_count, m_z, m_cnt);
            end
        end
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [LW-1:0] l,
                           input logic o, input logic clr);
        pattern = p; pat_len = l; overlap = o;
        step(1'b1, 1'b1, 1'b1, clr, 1'b0);
        pattern = '0; pat_len = '0; overlap = ~o;   // must not matter off-load
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (z !== 1'b0 || match_count !== '0) begin
            errors++;
            $display("FAIL reset: z=%b cnt=%0d, required z=0 cnt=0", z, match_count);
        end
    endtask

    task automatic test_default_overlap;
        feed(16'b0110110, 7);
        checks++;
        if (match_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL default_overlap count: %0d, required 2", match_count);
        end
    endtask

    task automatic test_non_overlap;
        do_load(4'b0110, 3'd4, 1'b0, 1'b1);
        feed(16'b0110110, 7);
        checks++;
        if (match_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL non_overlap count: %0d, required 1", match_count);
        end
        feed(16'b110110, 6);
    endtask

    task automatic test_valid_gaps;
        do_load(4'b0110, 3'd4, 1'b1, 1'b1);
        feed(16'b011, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        feed(16'b0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (z !== 1'b1) begin
                errors++;
                $display("FAIL valid_gap hold %0d: z=%b, required 1", i, z);
            end
        end
        feed(16'b1, 1);
        checks++;
        if (z !== 1'b0 || match_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL valid_gap end: z=%b cnt=%0d, required z=0 cnt=1", z, match_count);
        end
    endtask

    task automatic test_short_pattern;
        do_load(4'b0101, 3'd3, 1'b1, 1'b1);
        feed(16'b10101, 5);
        checks++;
        if (match_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL short_ovl count: %0d, required 2", match_count);
        end
        do_load(4'b0101, 3'd3, 1'b0, 1'b1);
        feed(16'b10101, 5);
        checks++;
        if (match_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL short_novl count: %0d, required 1", match_count);
        end
    endtask

    task automatic test_reset_load_mid;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        feed(16'b011, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        feed(16'b0, 1);
        checks++;
        if (z !== 1'b0 || match_count !== '0) begin
            errors++;
            $display("FAIL reset_mid: z=%b cnt=%0d, required z=0 cnt=0", z, match_count);
        end
        feed(16'b0110, 4);
        feed(16'b011, 3);
        do_load(4'b0110, 3'd4, 1'b1, 1'b0);
        feed(16'b0, 1);
        checks++;
        if (z !== 1'b0 || match_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL load_mid: z=%b cnt=%0d, required z=0 cnt=1", z, match_count);
        end
    endtask

    task automatic test_len_clamp;
        do_load(4'b0001, 3'd0, 1'b0, 1'b1);
        feed(16'b1011, 4);
        checks++;
        if (match_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL len0 count: %0d, required 3", match_count);
        end
        do_load(4'b0110, 3'd7, 1'b1, 1'b1);
        feed(16'b0110, 4);
        checks++;
        if (z !== 1'b1 || match_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL len7: z=%b cnt=%0d, required z=1 cnt=1", z, match_count);
        end
    endtask

    task automatic test_saturation;
        do_load(4'b0001, 3'd1, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (z !== 1'b1 || match_count !== CNT_W'(CMAX) || m_cnt != CMAX) begin
            errors++;
            $display("FAIL saturate: z=%b cnt=%0d, required z=1 cnt=%0d", z, match_count, CMAX);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (z !== 1'b1 || match_count !== '0) begin
            errors++;
            $display("FAIL clear_on_hit: z=%b cnt=%0d, required z=1 cnt=0", z, match_count);
        end
        feed(16'b1, 1);
        checks++;
        if (match_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL after_clear: cnt=%0d, required 1", match_count);
        end
    endtask

    task automatic test_random;
        logic v, b, ld, clr, rst;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom);
            if (ld) begin
                pattern = PAT_W'($urandom);
                pat_len = LW'($urandom_range(0, 7));
                overlap = 1'($urandom);
            end
            step(v, b, ld, clr, rst);
            pattern = PAT_W'($urandom); pat_len = LW'($urandom); overlap = 1'($urandom);
            checks++;
            if (z !== m_z || match_count !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL random cycle %0d: z=%b cnt=%0d, required z=%b cnt=%0d",
                         n, z, match_count, m_z, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset;
        test_default_overlap;
        test_non_overlap;
        test_valid_gaps;
        test_short_pattern;
        test_reset_load_mid;
        test_len_clamp;
        test_saturation;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
